// File: rtl/cntr_seq_pkg.sv
// Shared types for the counter sequencer: FSM states and run modes.
package cntr_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic {
        ONE_SHOT = 1'b0,
        PERIODIC = 1'b1
    } mode_t;

endpackage

// File: rtl/cntr_core.sv
// Counter datapath: synchronous up-counter with clear (priority) and enable.
module cntr_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/cntr_seq.sv
// Programmable timer sequencer around cntr_core: prescaled ticks, terminal
// compare, one-shot/periodic operation with start/pause/stop commands.
//
// state | meaning
// IDLE  | count held at 0, waiting for start
// RUN   | prescaler running, count advances on each tick
// PAUSE | count and prescaler frozen, still busy
// DONE  | one-shot finished, count held at limit_q
module cntr_seq
    import cntr_seq_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             mode,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PS_MAX = PW'(PRESCALE - 1);

    state_t           state, state_n;
    logic [PW-1:0]    prescaler, prescaler_n;
    logic [WIDTH-1:0] limit_q, limit_n;
    mode_t            mode_q, mode_n;
    logic             done_n, err_n;
    logic             clr, en, tick;

    assign tick = (prescaler == PS_MAX);
    assign busy = (state == RUN) || (state == PAUSE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            prescaler <= '0;
            limit_q   <= '0;
            mode_q    <= ONE_SHOT;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            prescaler <= prescaler_n;
            limit_q   <= limit_n;
            mode_q    <= mode_n;
            done      <= done_n;
            err       <= err_n;
        end
    end

    always_comb begin
        state_n     = state;
        prescaler_n = prescaler;
        limit_n     = limit_q;
        mode_n      = mode_q;
        done_n      = 1'b0;
        err_n       = 1'b0;
        clr         = 1'b0;
        en          = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (state == IDLE) begin
                    clr = 1'b1;
                end
                if (stop) begin
                    state_n     = IDLE;
                    prescaler_n = '0;
                    clr         = 1'b1;
                end else if (start) begin
                    if (limit != '0) begin
                        state_n     = RUN;
                        prescaler_n = '0;
                        limit_n     = limit;
                        mode_n      = mode_t'(mode);
                        clr         = 1'b1;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            RUN: begin
                if (stop) begin
                    state_n     = IDLE;
                    prescaler_n = '0;
                    clr         = 1'b1;
                end else if (pause) begin
                    state_n = PAUSE;
                end else if (tick) begin
                    prescaler_n = '0;
                    if (count == limit_q) begin
                        done_n = 1'b1;
                        if (mode_q == PERIODIC) begin
                            clr = 1'b1;
                        end else begin
                            state_n = DONE;
                        end
                    end else begin
                        en = 1'b1;
                    end
                end else begin
                    prescaler_n = prescaler + PW'(1);
                end
            end
            PAUSE: begin
                if (stop) begin
                    state_n     = IDLE;
                    prescaler_n = '0;
                    clr         = 1'b1;
                end else if (!pause) begin
                    state_n = RUN;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    cntr_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .en   (en),
        .count(count)
    );

endmodule

// File: tb/tb_cntr_seq.sv
// Directed bench for cntr_seq: two instances (PRESCALE=1 and PRESCALE=4) share stimulus.
module tb_cntr_seq;

    logic       clk = 1'b0;
    logic       rst, start, stop, pause, mode;
    logic [3:0] limit;
    logic [3:0] count1, count4;
    logic       busy1, done1, err1, busy4, done4, err4;
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    cntr_seq #(.WIDTH(4), .PRESCALE(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
        .mode(mode), .limit(limit), .count(count1), .busy(busy1),
        .done(done1), .err(err1)
    );

    cntr_seq #(.WIDTH(4), .PRESCALE(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
        .mode(mode), .limit(limit), .count(count4), .busy(busy4),
        .done(done4), .err(err4)
    );

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; mode = 1'b0; limit = 4'd0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({count1, busy1, done1, err1} !== 7'b0 || {count4, busy4, done4, err4} !== 7'b0) begin
                n_err++;
                $display("FAIL reset_idle cyc=%0d: dut1 c/b/d/e=%0d/%0b/%0b/%0b dut4 c/b/d/e=%0d/%0b/%0b/%0b expected all 0",
                         i, count1, busy1, done1, err1, count4, busy4, done4, err4);
            end
        end
    endtask

    task automatic test_oneshot();
        logic [3:0] exp_c [8] = '{0, 1, 2, 3, 3, 3, 3, 3};
        logic       exp_b [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
        logic       exp_d [8] = '{0, 0, 0, 0, 1, 0, 0, 0};
        int         dcnt = 0;
        do_reset();
        limit = 4'd3; mode = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; limit = 4'd0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            if (done1) dcnt++;
            n_cmp++;
            if (count1 !== exp_c[k] || busy1 !== exp_b[k] || done1 !== exp_d[k]) begin
                n_err++;
                $display("FAIL oneshot k=%0d: got c/b/d=%0d/%0b/%0b expected %0d/%0b/%0b",
                         k, count1, busy1, done1, exp_c[k], exp_b[k], exp_d[k]);
            end
        end
        n_cmp++;
        if (dcnt != 1) begin
            n_err++;
            $display("FAIL oneshot_done_count: got %0d expected 1", dcnt);
        end
    endtask

    task automatic test_periodic();
        int dcnt = 0;
        logic [3:0] ec;
        logic       ed;
        do_reset();
        limit = 4'd2; mode = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 38; k++) begin
            if (k > 0) @(negedge clk);
            ec = 4'((k / 4) % 3);
            ed = (k > 0) && (k % 12 == 0);
            if (done4) dcnt++;
            n_cmp++;
            if (count4 !== ec || done4 !== ed || busy4 !== 1'b1) begin
                n_err++;
                $display("FAIL periodic k=%0d: got c/d/b=%0d/%0b/%0b expected %0d/%0b/1",
                         k, count4, done4, busy4, ec, ed);
            end
        end
        n_cmp++;
        if (dcnt != 3) begin
            n_err++;
            $display("FAIL periodic_done_count: got %0d expected 3", dcnt);
        end
    endtask

    task automatic test_pause_stop();
        logic [3:0] exp_c [16] = '{0, 1, 2, 3, 4, 4, 4, 4, 4, 4, 4, 5, 6, 7, 0, 0};
        logic       exp_b [16] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
        do_reset();
        limit = 4'd9; mode = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (k > 0) @(negedge clk);
            n_cmp++;
            if (count1 !== exp_c[k] || busy1 !== exp_b[k] || done1 !== 1'b0) begin
                n_err++;
                $display("FAIL pause_stop k=%0d: got c/b/d=%0d/%0b/%0b expected %0d/%0b/0",
                         k, count1, busy1, done1, exp_c[k], exp_b[k]);
            end
            pause = (k >= 4 && k <= 8);
            stop  = (k == 13);
        end
        stop = 1'b0;
    endtask

    task automatic test_limit_zero();
        do_reset();
        limit = 4'd0; mode = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (err1 !== 1'b1 || busy1 !== 1'b0 || err4 !== 1'b1 || busy4 !== 1'b0) begin
            n_err++;
            $display("FAIL limit_zero_err: got err1/busy1/err4/busy4=%0b/%0b/%0b/%0b expected 1/0/1/0",
                     err1, busy1, err4, busy4);
        end
        @(negedge clk);
        n_cmp++;
        if (err1 !== 1'b0 || busy1 !== 1'b0 || count1 !== 4'd0) begin
            n_err++;
            $display("FAIL limit_zero_after: got err/busy/count=%0b/%0b/%0d expected 0/0/0",
                     err1, busy1, count1);
        end
    endtask

    task automatic test_start_in_run();
        logic [3:0] ec;
        logic       ed;
        do_reset();
        limit = 4'd2; mode = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 26; k++) begin
            if (k > 0) @(negedge clk);
            ec = 4'((k / 4) % 3);
            ed = (k > 0) && (k % 12 == 0);
            n_cmp++;
            if (count4 !== ec || done4 !== ed || err4 !== 1'b0) begin
                n_err++;
                $display("FAIL start_in_run k=%0d: got c/d/e=%0d/%0b/%0b expected %0d/%0b/0",
                         k, count4, done4, err4, ec, ed);
            end
            start = (k == 2);
            limit = (k == 2) ? 4'd5 : 4'd2;
        end
        start = 1'b0;
    endtask

    task automatic test_relaunch();
        logic [3:0] exp_c [8] = '{0, 1, 1, 1, 0, 1, 2, 2};
        logic       exp_b [8] = '{1, 1, 0, 0, 1, 1, 1, 0};
        logic       exp_d [8] = '{0, 0, 1, 0, 0, 0, 0, 1};
        do_reset();
        limit = 4'd1; mode = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            n_cmp++;
            if (count1 !== exp_c[k] || busy1 !== exp_b[k] || done1 !== exp_d[k]) begin
                n_err++;
                $display("FAIL relaunch k=%0d: got c/b/d=%0d/%0b/%0b expected %0d/%0b/%0b",
                         k, count1, busy1, done1, exp_c[k], exp_b[k], exp_d[k]);
            end
            start = (k == 3);
            limit = (k == 3) ? 4'd2 : 4'd0;
        end
        start = 1'b0;
    endtask

    task automatic test_rst_in_pause();
        do_reset();
        limit = 4'd9; mode = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        pause = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (count1 !== 4'd2 || busy1 !== 1'b1) begin
            n_err++;
            $display("FAIL rst_pause_pre: got c/b=%0d/%0b expected 2/1", count1, busy1);
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({count1, busy1, done1, err1} !== 7'b0 || {count4, busy4, done4, err4} !== 7'b0) begin
            n_err++;
            $display("FAIL rst_pause_post: dut1 c/b/d/e=%0d/%0b/%0b/%0b dut4 c/b=%0d/%0b expected all 0",
                     count1, busy1, done1, err1, count4, busy4);
        end
        rst = 1'b0; pause = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (count1 !== 4'd0 || busy1 !== 1'b0) begin
            n_err++;
            $display("FAIL rst_pause_idle: got c/b=%0d/%0b expected 0/0", count1, busy1);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; mode = 1'b0; limit = 4'd0;
        test_reset();
        test_oneshot();
        test_periodic();
        test_pause_stop();
        test_limit_zero();
        test_start_in_run();
        test_relaunch();
        test_rst_in_pause();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cntr_seq.md
Name: cntr_seq

Overview:
Sequencing controller for the team's synchronous up-counter datapath. Turns the free-running counter into a programmable timer:
- start, pause and stop commands
- prescaled count ticks
- terminal-value compare
- one-shot or periodic operation, with a done pulse per period

Sits between control logic or a register interface and the counter; drives the counter's clear/enable and exposes the count.

Parameters:
WIDTH, 4, counter and limit width in bits
PRESCALE, 4, clock cycles per count tick (≥1; 1 = tick every cycle)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  arm/launch request, sampled each cycle
stop  input  1  abort, returns to IDLE
pause  input  1  level; freezes counting while high in RUN
mode  input  1  0 = one-shot, 1 = periodic; latched on accepted start
limit  input  WIDTH  terminal count value; latched on accepted start
count  output  WIDTH  current count
busy  output  1  high in RUN and PAUSE
done  output  1  one-cycle pulse at end of each period
err  output  1  one-cycle pulse when start is rejected

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset: state IDLE, count=0, prescaler=0, limit_q=0, mode_q=0, busy=0, done=0, err=0.
- Reset mid-operation: the same values are applied at the next edge, regardless of state.
- States: IDLE, RUN, PAUSE, DONE.
- Command priority each cycle: rst > stop > start > pause > tick.

IDLE:
- count held at 0.
- start=1 with limit≠0: latch limit_q and mode_q, clear prescaler, go to RUN.
- start=1 with limit=0: err=1 for one cycle, stay in IDLE.

RUN:
- Prescaler counts 0..PRESCALE-1. tick = (prescaler==PRESCALE-1); prescaler wraps to 0 on tick.
- On tick with count≠limit_q: count+1.
- On tick with count==limit_q:
  - done=1 the next cycle, registered with the same edge.
  - mode_q=0: go to DONE, count held at limit_q.
  - mode_q=1: count←0, stay in RUN.
- pause=1: go to PAUSE. No tick or increment occurs in that cycle, even if tick would have fired; the prescaler is frozen.
- start while in RUN is ignored. No relatch, no err.

PAUSE:
- count and prescaler frozen; busy stays 1.
- pause=0: return to RUN and resume from the frozen prescaler value.

DONE:
- busy=0; count held at limit_q.
- start relaunches exactly as from IDLE, including relatch and the limit=0 check; count←0.

stop, any non-IDLE state:
- Next edge: IDLE, count=0, prescaler=0, no done.
- stop wins over a simultaneous tick or terminal count.

Timing and widths:
- Latency: an accepted start at edge E gives busy=1 and count=0 after E. First done is high in the cycle after edge E+(limit_q+1)·PRESCALE.
- Periodic period: (limit_q+1)·PRESCALE cycles, done every period.
- count never exceeds limit_q, so there is no WIDTH overflow.
- Prescaler width is $clog2(PRESCALE), minimum 1 bit.
- limit/mode changes after acceptance have no effect until the next accepted start.

Decomposition:
- Package cntr_seq_pkg holds:
  - state_t enum {IDLE, RUN, PAUSE, DONE}
  - mode_t enum {ONE_SHOT=0, PERIODIC=1}
- Sub-module cntr_core(WIDTH): the counter datapath. Ports clk, rst, clr, en, count.
  - Synchronous clear has priority over enable.
  - cntr_seq drives clr on stop, terminal wrap and launch, and en on tick.
- Prescaler and FSM stay in cntr_seq.

Test Plan:
- Reset then idle: rst high 2 cycles, no commands → count=0, busy=0, done=0, err=0 for 10 cycles.
- One-shot, PRESCALE=1, limit=3, mode=0, start 1 cycle → count 0,1,2,3 on successive cycles; done pulses exactly once 4 cycles after busy rises; state DONE; count stays 3; busy=0.
- Periodic, PRESCALE=4, limit=2, mode=1 → done pulses every 12 cycles, 3 periods observed; count sequence 0,0,0,0,1,1,1,1,2,2,2,2,0…
- Pause/stop mid-run: PRESCALE=1, limit=9, pause high 5 cycles at count=4 → count holds 4, busy=1, then resumes at 5. Later, stop at count=7 coincident with tick → IDLE, count=0, no done.
- Boundary cases:
  - start with limit=0 → err pulse, busy stays 0.
  - start during RUN with a new limit → ignored; the original period is kept.
- Relaunch and reset:
  - start in DONE → count=0, busy=1, new limit honoured.
  - rst asserted in PAUSE → all outputs return to reset values next cycle.
